// File: rtl/store_buffer.sv
// Word-store FIFO between MEM-stage load/store logic and a single-port data memory.
// Define STORE_BUF_FWD_EN to forward pending store data to loads; otherwise matching loads stall.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic              empty,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_re_data
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);
  localparam int WORD_W = ADDR_W - 2;

  logic [WORD_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SC_W-1:0]   r_starve;

  logic w_hit;
  logic w_drain_force;
  logic w_ld_req;
  logic w_load;
  logic w_drain;
  logic w_push;
  logic w_unused_st_lsb;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] w_fwd_data;
`endif

  assign w_unused_st_lsb = ^st_addr[1:0];
  assign st_ready = (r_count != CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = st_valid && st_ready;

  // Walk valid entries oldest to youngest so the youngest matching store wins.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    w_fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) &&
          (r_addr[r_rd_ptr + PTR_W'(k)] == ld_addr[ADDR_W-1:2])) begin
        w_hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        w_fwd_data = r_data[r_rd_ptr + PTR_W'(k)];
`endif
      end
    end
  end

  // A load to a word still pending in the buffer is invisible to arbitration
  // when forwarding is off, letting the drain clear the conflict.
  always_comb begin
    w_drain_force = (r_count != '0) && (r_starve == SC_W'(STARVE_MAX));
`ifdef STORE_BUF_FWD_EN
    w_ld_req = ld_valid;
`else
    w_ld_req = ld_valid && !w_hit;
`endif
    w_load  = w_ld_req && !w_drain_force;
    w_drain = !w_load && (r_count != '0);
  end

  always_comb begin
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_address  = '0;
    mem_wr_data  = '0;
    if (w_load) begin
      mem_r_enable = 1'b1;
      mem_address  = ld_addr;
    end else if (w_drain) begin
      mem_w_enable = 1'b1;
      mem_address  = {r_addr[r_rd_ptr], 2'b00};
      mem_wr_data  = r_data[r_rd_ptr];
    end
  end

  assign ld_stall = ld_valid && !w_load;
`ifdef STORE_BUF_FWD_EN
  assign ld_data = w_hit ? w_fwd_data : mem_re_data;
`else
  assign ld_data = mem_re_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drain) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_drain);
      if (w_drain || (r_count == '0))
        r_starve <= '0;
      else if (w_load && (r_starve != SC_W'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end

  // NOTE: entry storage has no reset; contents are only read when covered by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr[ADDR_W-1:2];
      r_data[r_wr_ptr] <= st_data;
    end
  end

endmodule
